// File: rtl/feistel_cipher_core.sv
// Iterative 64-bit Feistel cipher (encrypt/decrypt), ROUNDS_PER_CYC rounds per clock, NR rounds total.
// Optional input/output key whitening is enabled by defining FEISTEL_KEY_WHITEN_EN (adds port in_wkey).
module feistel_cipher_core #(
   parameter int NR             = 8,
   parameter int ROUNDS_PER_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [63:0]       in_data,
   input  logic [16*NR-1:0]  in_key,
   input  logic              in_dec,
`ifdef FEISTEL_KEY_WHITEN_EN
   input  logic [63:0]       in_wkey,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data
);

   localparam int C  = (ROUNDS_PER_CYC > 0) ? NR / ROUNDS_PER_CYC : 1;
   localparam int CW = (C > 1) ? $clog2(C) : 1;

   generate
      if (NR < 1 || ROUNDS_PER_CYC < 1 || (NR % ROUNDS_PER_CYC) != 0) begin : g_bad_cfg
         $error("feistel_cipher_core: ROUNDS_PER_CYC must divide NR (NR >= 1)");
      end
   endgenerate

   // Handshake: a transfer happens on any rising edge where valid and ready are both high.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic [31:0]          l_q, r_q, l_n, r_n;
   logic [16*NR-1:0]     key_q, key_rev;
   logic [63:0]          load_blk, result;
   logic                 accept, last;

   function automatic logic [7:0] rol2(input logic [7:0] x);
      return {x[5:0], x[7:6]};
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [15:0] k);
      logic [7:0] f1, f2, g0, g1, g2, g3;
      f1 = r[31:24] ^ r[23:16] ^ k[15:8];
      f2 = r[15:8] ^ r[7:0] ^ k[7:0];
      g1 = rol2(f1 + f2 + 8'd1);
      g2 = rol2(g1 + f2);
      g0 = rol2(g1 + r[31:24]);
      g3 = rol2(g2 + r[7:0] + 8'd1);
      return {g0, g1, g2, g3};
   endfunction

   assign accept = (state_q == IDLE) && in_ready && in_valid;
   assign last   = (cnt_q == CW'(C - 1));

   // Decrypt runs the same datapath with the round keys pre-reversed at accept.
   always_comb begin
      key_rev = '0;
      for (int i = 0; i < NR; i++) begin
         key_rev[16*i +: 16] = in_key[16*(NR-1-i) +: 16];
      end
   end

   always_comb begin
      logic [31:0] l, r, t;
      l = l_q;
      r = r_q;
      t = '0;
      for (int i = 0; i < ROUNDS_PER_CYC; i++) begin
         t = l ^ f_func(r, key_q[16*i +: 16]);
         l = r;
         r = t;
      end
      l_n = l;
      r_n = r;
   end

`ifdef FEISTEL_KEY_WHITEN_EN
   logic [63:0] wkey_q;
   assign load_blk = in_data ^ in_wkey;
   assign result   = {r_n, l_n} ^ wkey_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      wkey_q <= '0;
      else if (accept) wkey_q <= in_wkey;
   end
`else
   assign load_blk = in_data;
   assign result   = {r_n, l_n};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         cnt_q     <= '0;
         l_q       <= '0;
         r_q       <= '0;
         key_q     <= '0;
      end else begin
         in_ready <= (state_d == IDLE);
         if (accept) begin
            l_q   <= load_blk[63:32];
            r_q   <= load_blk[31:0];
            key_q <= in_dec ? key_rev : in_key;
            cnt_q <= '0;
         end else if (state_q == RUN) begin
            l_q   <= l_n;
            r_q   <= r_n;
            key_q <= key_q >> (16 * ROUNDS_PER_CYC);
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
               out_valid <= 1'b1;
               out_data  <= result;
            end
         end else if (state_q == DONE && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_feistel_cipher_core.sv
// Directed bench for feistel_cipher_core: three instances (NR=8/RPC=1, NR=8/RPC=4, NR=1/RPC=1)
// checked against a behavioural cipher model through an expected-result queue.
module tb_feistel_cipher_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       in_valid, in_ready, in_dec, out_valid, out_ready;
   logic [2:0][63:0] in_data, out_data, wkey;
   logic [127:0]     key_a, key_b;
   logic [15:0]      key_c;

   logic [63:0] exp_q[$];
   int n_checks = 0;
   int n_err = 0;
   int lat_c[3] = '{8, 2, 1};
   int nr_of[3] = '{8, 8, 1};

   feistel_cipher_core #(.NR(8), .ROUNDS_PER_CYC(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_key(key_a), .in_dec(in_dec[0]),
`ifdef FEISTEL_KEY_WHITEN_EN
      .in_wkey(wkey[0]),
`endif
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));

   feistel_cipher_core #(.NR(8), .ROUNDS_PER_CYC(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_key(key_b), .in_dec(in_dec[1]),
`ifdef FEISTEL_KEY_WHITEN_EN
      .in_wkey(wkey[1]),
`endif
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));

   feistel_cipher_core #(.NR(1), .ROUNDS_PER_CYC(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .in_key(key_c), .in_dec(in_dec[2]),
`ifdef FEISTEL_KEY_WHITEN_EN
      .in_wkey(wkey[2]),
`endif
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

   function automatic logic [7:0] m_rol2(input logic [7:0] x);
      return {x[5:0], x[7:6]};
   endfunction

   function automatic logic [31:0] m_f(input logic [31:0] r, input logic [15:0] k);
      logic [7:0] r3, r2, r1, r0, f1, f2, g0, g1, g2, g3;
      {r3, r2, r1, r0} = r;
      f1 = r3 ^ r2 ^ k[15:8];
      f2 = r1 ^ r0 ^ k[7:0];
      g1 = m_rol2(8'(f1 + f2 + 8'd1));
      g2 = m_rol2(8'(g1 + f2));
      g0 = m_rol2(8'(g1 + r3));
      g3 = m_rol2(8'(g2 + r0 + 8'd1));
      return {g0, g1, g2, g3};
   endfunction

   function automatic logic [63:0] model(input logic [63:0] d, input logic [127:0] k,
                                         input int nr, input logic dec, input logic [63:0] wk);
      logic [31:0] l, r, t;
      logic [63:0] x;
      int ki;
      x = d ^ wk;
      l = x[63:32];
      r = x[31:0];
      for (int i = 0; i < nr; i++) begin
         ki = dec ? nr - 1 - i : i;
         t = l ^ m_f(r, k[16*ki +: 16]);
         l = r;
         r = t;
      end
      return {r, l} ^ wk;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input int s);
      int n = 0;
      while (in_ready[s] !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", 64'(in_ready[s]), 64'd1);
   endtask

   task automatic set_key(input int s, input logic [127:0] k);
      case (s)
         0:       key_a = k;
         1:       key_b = k;
         default: key_c = k[15:0];
      endcase
   endtask

   // Drive one block, push its model result, then scramble key/mode/data during RUN.
   task automatic send(input int s, input logic [63:0] d, input logic [127:0] k,
                       input logic dec, input logic [63:0] wk, input logic early);
      wait_ready(s);
      exp_q.push_back(model(d, k, nr_of[s], dec, wk));
      in_valid[s] = 1'b1;
      in_data[s]  = d;
      in_dec[s]   = dec;
      wkey[s]     = wk;
      set_key(s, k);
      @(posedge clk); #1;
      in_valid[s] = 1'b0;
      in_data[s]  = {$urandom, $urandom};
      in_dec[s]   = ~dec;
      wkey[s]     = {$urandom, $urandom};
      set_key(s, {$urandom, $urandom, $urandom, $urandom});
      if (early) out_ready[s] = 1'b1;
      check("in_ready_busy", 64'(in_ready[s]), 64'd0);
   endtask

   task automatic collect(input int s, input int hold);
      int lat = 0;
      logic [63:0] exp, held;
      while (out_valid[s] !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(lat_c[s]));
      held = out_data[s];
      for (int i = 0; i < hold; i++) begin
         in_valid[s] = 1'b1;
         in_data[s]  = {$urandom, $urandom};
         @(posedge clk); #1;
         check("hold_valid", 64'(out_valid[s]), 64'd1);
         check("hold_data", out_data[s], held);
         check("hold_in_ready", 64'(in_ready[s]), 64'd0);
      end
      in_valid[s] = 1'b0;
      check("sb_depth", 64'(exp_q.size()), 64'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      check("out_data", out_data[s], exp);
      out_ready[s] = 1'b1;
      @(posedge clk); #1;
      out_ready[s] = 1'b0;
      check("out_valid_drop", 64'(out_valid[s]), 64'd0);
      check("in_ready_back", 64'(in_ready[s]), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0]  p, ct, d;
      logic [127:0] k;
      logic         dec;
      int           s;
      p  = 64'h0123456789ABCDEF;
      k  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      ct = model(p, k, 8, 1'b0, 64'd0);
      in_valid = '0; in_dec = '0; out_ready = '0;
      in_data = '0; wkey = '0; key_a = '0; key_b = '0; key_c = '0;

      // Reset state, then in_ready rises at the first edge after release.
      #22;
      check("rst_in_ready", 64'(in_ready[0]), 64'd0);
      check("rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("rst_out_data", out_data[0], 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_in_ready", 64'(in_ready[0]), 64'd1);

      // NR=1 known-answer vector.
      send(2, 64'd0, 128'd0, 1'b0, 64'd0, 1'b0);
      collect(2, 0);
      check("nr1_vector", out_data[2], 64'h10041044_00000000);

      // NR=8 encrypt then decrypt, single round per clock.
      send(0, p, k, 1'b0, 64'd0, 1'b0);
      collect(0, 0);
      send(0, ct, k, 1'b1, 64'd0, 1'b0);
      collect(0, 0);
      check("roundtrip_rpc1", out_data[0], p);

      // Four rounds per clock gives the same ciphertext in two edges.
      send(1, p, k, 1'b0, 64'd0, 1'b0);
      collect(1, 0);
      check("rpc4_ct", out_data[1], ct);
      send(1, ct, k, 1'b1, 64'd0, 1'b1);
      collect(1, 0);
      check("roundtrip_rpc4", out_data[1], p);

      // Backpressure: result held 10 cycles while in_valid is ignored.
      send(0, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 64'd0, 1'b0);
      collect(0, 10);

      // out_ready while idle has no effect.
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      check("idle_out_valid", 64'(out_valid[0]), 64'd0);
      check("idle_in_ready", 64'(in_ready[0]), 64'd1);

      // Random blocks across all instances.
      for (int i = 0; i < 6; i++) begin
         s   = $urandom_range(0, 2);
         d   = {$urandom, $urandom};
         k   = {$urandom, $urandom, $urandom, $urandom};
         dec = 1'($urandom_range(0, 1));
         send(s, d, k, dec, 64'd0, 1'($urandom_range(0, 1)));
         collect(s, 0);
      end

      // Reset during RUN cycle 3 aborts the block.
      k = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      send(0, p, k, 1'b0, 64'd0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid[0]), 64'd0);
      check("abort_out_data", out_data[0], 64'd0);
      check("abort_in_ready", 64'(in_ready[0]), 64'd0);
      exp_q.delete();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
      check("post_rst_out_valid", 64'(out_valid[0]), 64'd0);
      send(0, p, k, 1'b0, 64'd0, 1'b0);
      collect(0, 0);
      check("post_rst_ct", out_data[0], ct);

`ifdef FEISTEL_KEY_WHITEN_EN
      // Whitened NR=1 round trip.
      send(2, 64'd0, 128'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
      collect(2, 0);
      send(2, model(64'd0, 128'd0, 1, 1'b0, 64'hFFFFFFFF_FFFFFFFF), 128'd0, 1'b1,
           64'hFFFFFFFF_FFFFFFFF, 1'b0);
      collect(2, 0);
      check("whiten_roundtrip", out_data[2], 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
